// File: rtl/sm_ahb_ram_slave_pkg.sv
// Shared AHB-Lite codes, FSM state encoding and helpers for sm_ahb_ram_slave.
package sm_ahb_ram_slave_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    // NONSEQ and SEQ are the only transfer types that carry data
    function automatic logic trans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/sm_ahb_ram_slave_if.sv
// AHB-Lite bus bundle between the host side (master) and the RAM responder (slave).
interface sm_ahb_ram_slave_if;
    import sm_ahb_ram_slave_pkg::*;

    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic              HWRITE;
    logic [1:0]        HTRANS;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADY;
    logic [DATA_W-1:0] HRDATA;
    logic              HREADYOUT;
    logic              HRESP;

    modport master (
        output HSEL, HADDR, HWRITE, HTRANS, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWRITE, HTRANS, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/sm_ahb_wait_cnt.sv
// Loadable down-counter for data-phase wait states, with a zero flag.
module sm_ahb_wait_cnt
    import sm_ahb_ram_slave_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt_q;

    // Load has priority over decrement; decrement saturates at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/sm_ahb_ram_slave.sv
// AHB-Lite word RAM responder with programmable wait states.
// Optional feature macro: SM_AHB_RAM_ERR_EN (range/alignment check with ERROR response).
module sm_ahb_ram_slave
    import sm_ahb_ram_slave_pkg::*;
#(
    parameter int unsigned       SIZE        = 64,
    parameter logic [ADDR_W-1:0] ADDR_BASE   = 32'h2000_0000,
    parameter int unsigned       WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    sm_ahb_ram_slave_if.slave bus
);

    localparam int unsigned       IDX_W = $clog2(SIZE);
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(4 * SIZE);
    localparam logic [CNT_W-1:0]  WS    = CNT_W'(WAIT_STATES);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q;
    logic                write_q;
    logic [DATA_W-1:0]   mem [SIZE];

    logic [ADDR_W-1:0]   offset;
    logic [IDX_W-1:0]    idx;
    logic                accept;
    logic                in_range;
    logic                phase_open;
    logic                mem_we;
    logic                cnt_load;
    logic                cnt_dec;
    logic                cnt_zero;

    // Address-phase decode: accept qualifier, word index and range check
    always_comb begin
        accept = bus.HSEL && trans_active(bus.HTRANS) && bus.HREADY;
        offset = bus.HADDR - ADDR_BASE;
        idx    = IDX_W'(offset >> 2);
`ifdef SM_AHB_RAM_ERR_EN
        in_range = (bus.HADDR >= ADDR_BASE) && (offset < SPAN) &&
                   (bus.HADDR[1:0] == 2'b00);
`else
        in_range = 1'b1;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, bus responses and data-phase strobes
    always_comb begin
        state_d       = state_q;
        bus.HREADYOUT = 1'b1;
        bus.HRESP     = HRESP_OKAY;
        bus.HRDATA    = '0;
        phase_open    = 1'b0;
        mem_we        = 1'b0;
        cnt_load      = 1'b0;
        cnt_dec       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                phase_open = 1'b1;
            end
            ST_DATA: begin
                bus.HREADYOUT = cnt_zero;
                if (cnt_zero) begin
                    phase_open = 1'b1;
                    state_d    = ST_IDLE;
                    if (write_q) begin
                        mem_we = 1'b1;
                    end else begin
                        bus.HRDATA = mem[idx_q];
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_ERR1: begin
                bus.HREADYOUT = 1'b0;
                bus.HRESP     = HRESP_ERROR;
                state_d       = ST_ERR2;
            end
            ST_ERR2: begin
                bus.HRESP  = HRESP_ERROR;
                phase_open = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A new address phase may only be taken when this slave is ready
        if (phase_open && accept) begin
            if (in_range) begin
                state_d  = ST_DATA;
                cnt_load = 1'b1;
            end else begin
                state_d = ST_ERR1;
            end
        end
    end

    // Address-phase registers for the upcoming data phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            write_q <= 1'b0;
        end else if (phase_open && accept) begin
            idx_q   <= idx;
            write_q <= bus.HWRITE;
        end
    end

    // Memory array write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= bus.HWDATA;
        end
    end

    sm_ahb_wait_cnt u_wait_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (WS),
        .dec      (cnt_dec),
        .zero_c   (cnt_zero)
    );

endmodule

// File: tb/tb_sm_ahb_ram_slave.sv
// Directed bench for sm_ahb_ram_slave: three instances with 0, 2 and 3 wait states
// share the address/data lines; only the selected one sees HSEL.
`timescale 1ns/1ps
module tb_sm_ahb_ram_slave;
    import sm_ahb_ram_slave_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic        hwrite = 1'b0;
    logic [1:0]  htrans = HTRANS_IDLE;
    logic [31:0] hwdata = '0;

    logic [31:0] obs_rdata;
    logic        obs_ready;
    logic        obs_resp;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sm_ahb_ram_slave_if if_ws0 ();
    sm_ahb_ram_slave_if if_ws2 ();
    sm_ahb_ram_slave_if if_ws3 ();

    assign if_ws0.HSEL   = hsel && (sel == 2'd0);
    assign if_ws2.HSEL   = hsel && (sel == 2'd1);
    assign if_ws3.HSEL   = hsel && (sel == 2'd2);
    assign if_ws0.HADDR  = haddr;
    assign if_ws2.HADDR  = haddr;
    assign if_ws3.HADDR  = haddr;
    assign if_ws0.HWRITE = hwrite;
    assign if_ws2.HWRITE = hwrite;
    assign if_ws3.HWRITE = hwrite;
    assign if_ws0.HTRANS = htrans;
    assign if_ws2.HTRANS = htrans;
    assign if_ws3.HTRANS = htrans;
    assign if_ws0.HWDATA = hwdata;
    assign if_ws2.HWDATA = hwdata;
    assign if_ws3.HWDATA = hwdata;
    assign if_ws0.HREADY = if_ws0.HREADYOUT;
    assign if_ws2.HREADY = if_ws2.HREADYOUT;
    assign if_ws3.HREADY = if_ws3.HREADYOUT;

    sm_ahb_ram_slave #(.SIZE(64), .ADDR_BASE(32'h2000_0000), .WAIT_STATES(0))
        u_dut_ws0 (.clk(clk), .rst_n(rst_n), .bus(if_ws0));
    sm_ahb_ram_slave #(.SIZE(64), .ADDR_BASE(32'h2000_0000), .WAIT_STATES(2))
        u_dut_ws2 (.clk(clk), .rst_n(rst_n), .bus(if_ws2));
    sm_ahb_ram_slave #(.SIZE(64), .ADDR_BASE(32'h2000_0000), .WAIT_STATES(3))
        u_dut_ws3 (.clk(clk), .rst_n(rst_n), .bus(if_ws3));

    // Responses of the currently selected instance
    always_comb begin
        case (sel)
            2'd1:    begin obs_rdata = if_ws2.HRDATA; obs_ready = if_ws2.HREADYOUT; obs_resp = if_ws2.HRESP; end
            2'd2:    begin obs_rdata = if_ws3.HRDATA; obs_ready = if_ws3.HREADYOUT; obs_resp = if_ws3.HRESP; end
            default: begin obs_rdata = if_ws0.HRDATA; obs_ready = if_ws0.HREADYOUT; obs_resp = if_ws0.HRESP; end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One isolated transfer; returns on the negedge of the completing data cycle
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int stalls,
                        output logic resp_first, output logic resp_last);
        int budget;
        @(negedge clk);
        hsel   = 1'b1;
        htrans = HTRANS_NONSEQ;
        haddr  = addr;
        hwrite = wr;
        @(negedge clk);
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        hwdata = wdata;
        stalls = 0;
        budget = 0;
        resp_first = obs_resp;
        while (!obs_ready && budget < 32) begin
            stalls++;
            budget++;
            @(negedge clk);
        end
        if (budget >= 32) check("xfer_timeout", 32'(budget), 32'd0);
        rdata     = obs_rdata;
        resp_last = obs_resp;
    endtask

    logic [31:0] rd;
    int          st;
    logic        rf, rl;

    initial begin
        // Reset state
        #1;
        check("rst_ready", 32'(obs_ready), 32'd1);
        check("rst_resp",  32'(obs_resp),  32'd0);
        check("rst_rdata", obs_rdata,      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: zero-wait write then read
        sel = 2'd0;
        xfer(1'b1, 32'h2000_0004, 32'hDEAD_BEEF, rd, st, rf, rl);
        check("t1_wr_stall", 32'(st), 32'd0);
        xfer(1'b0, 32'h2000_0004, 32'h0, rd, st, rf, rl);
        check("t1_rd_stall", 32'(st), 32'd0);
        check("t1_rd_data",  rd, 32'hDEAD_BEEF);

        // 2: two wait states on a read
        sel = 2'd1;
        xfer(1'b1, 32'h2000_0000, 32'hA5A5_0001, rd, st, rf, rl);
        check("t2_wr_stall", 32'(st), 32'd2);
        xfer(1'b0, 32'h2000_0000, 32'h0, rd, st, rf, rl);
        check("t2_rd_stall", 32'(st), 32'd2);
        check("t2_rd_data",  rd, 32'hA5A5_0001);
        check("t2_rd_resp",  32'(rl), 32'd0);

        // 3: back-to-back write then read of the same word
        sel = 2'd0;
        @(negedge clk);
        hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h2000_0008; hwrite = 1'b1;
        @(negedge clk);
        check("t3_wr_ready", 32'(obs_ready), 32'd1);
        hwdata = 32'h1234_5678; hwrite = 1'b0;
        @(negedge clk);
        hsel = 1'b0; htrans = HTRANS_IDLE;
        check("t3_rd_ready", 32'(obs_ready), 32'd1);
        check("t3_rd_data",  obs_rdata, 32'h1234_5678);

        // 4: IDLE transfer type with HWRITE set does nothing
        xfer(1'b1, 32'h2000_0000, 32'h0BAD_0000, rd, st, rf, rl);
        @(negedge clk);
        hsel = 1'b1; htrans = HTRANS_IDLE; haddr = 32'h2000_0000; hwrite = 1'b1;
        @(negedge clk);
        hsel = 1'b0; hwdata = 32'hFFFF_FFFF;
        check("t4_ready", 32'(obs_ready), 32'd1);
        check("t4_resp",  32'(obs_resp),  32'd0);
        @(negedge clk);
        check("t4_ready2", 32'(obs_ready), 32'd1);
        xfer(1'b0, 32'h2000_0000, 32'h0, rd, st, rf, rl);
        check("t4_mem0", rd, 32'h0BAD_0000);

        // 5: write one past the end of the array
        xfer(1'b1, 32'h2000_0100, 32'h600D_CAFE, rd, st, rf, rl);
`ifdef SM_AHB_RAM_ERR_EN
        check("t5_err_stall", 32'(st), 32'd1);
        check("t5_resp_first", 32'(rf), 32'd1);
        check("t5_resp_last",  32'(rl), 32'd1);
        xfer(1'b0, 32'h2000_0000, 32'h0, rd, st, rf, rl);
        check("t5_mem0_old", rd, 32'h0BAD_0000);
        xfer(1'b1, 32'h2000_0002, 32'h1111_1111, rd, st, rf, rl);
        check("t5_misalign_resp", 32'(rl), 32'd1);
        xfer(1'b0, 32'h1FFF_FFFC, 32'h0, rd, st, rf, rl);
        check("t5_below_resp", 32'(rf), 32'd1);
        xfer(1'b0, 32'h2000_0000, 32'h0, rd, st, rf, rl);
        check("t5_after_err_resp", 32'(rl), 32'd0);
        check("t5_after_err_data", rd, 32'h0BAD_0000);
`else
        check("t5_stall",     32'(st), 32'd0);
        check("t5_resp_last", 32'(rl), 32'd0);
        xfer(1'b0, 32'h2000_0000, 32'h0, rd, st, rf, rl);
        check("t5_mem0_wrap", rd, 32'h600D_CAFE);
`endif

        // 6: reset during the wait-state stall drops the pending write
        sel = 2'd2;
        xfer(1'b1, 32'h2000_000C, 32'h0000_AAAA, rd, st, rf, rl);
        check("t6_wr_stall", 32'(st), 32'd3);
        @(negedge clk);
        hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h2000_000C; hwrite = 1'b1;
        @(negedge clk);
        hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'h0000_5555;
        check("t6_stall_low", 32'(obs_ready), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_ready", 32'(obs_ready), 32'd1);
        check("t6_rst_resp",  32'(obs_resp),  32'd0);
        check("t6_rst_rdata", obs_rdata,      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b0, 32'h2000_000C, 32'h0, rd, st, rf, rl);
        check("t6_word_kept", rd, 32'h0000_AAAA);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
